// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - shared widths, dispatch codes, microword and FSM types for the control store
package micro_pkg;

  localparam int ADR_W  = 4;
  localparam int CTRL_W = 13;

  // Sequencer dispatch codes carried in nextAdr; the store passes them through untouched.
  localparam logic [ADR_W-1:0] DISPATCH_OP    = 4'b1111;
  localparam logic [ADR_W-1:0] DISPATCH_FUNCT = 4'b1110;

  typedef struct packed {
    logic [ADR_W-1:0]  nextAdr;
    logic [CTRL_W-1:0] ctrl;
  } micro_word_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } store_state_e;

endpackage

// File: rtl/microcode_array.sv
// rtl/microcode_array.sv - microword storage with sync write, async read and per-entry valid bits
module microcode_array
  import micro_pkg::*;
#(
  parameter int AW    = ADR_W,
  parameter int DEPTH = 2 ** AW,
  parameter int WW    = ADR_W + CTRL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          clr_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o,
  output logic          rvalid_o
);

  logic [WW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Contents are deliberately not reset; the valid bits alone decide what is readable.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = '0;
    end
    if (we_i) begin
      valid_d[waddr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rdata_o  = mem_q[raddr_i];
  assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/microcode_store.sv
// rtl/microcode_store.sv - writable control store: boot-time load handshake, zero-latency microword read
module microcode_store
  import micro_pkg::*;
#(
  parameter int ADR_W  = micro_pkg::ADR_W,
  parameter int DEPTH  = 2 ** ADR_W,
  parameter int CTRL_W = micro_pkg::CTRL_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [ADR_W-1:0]        load_addr,
  input  logic [ADR_W+CTRL_W-1:0] load_data,
  input  logic                    load_last,
  input  logic                    reload,
  input  logic [ADR_W-1:0]        adr,
  output logic [ADR_W-1:0]        nextAdr,
  output logic [CTRL_W-1:0]       ctrl,
  output logic                    run,
  output logic                    fault
);

  store_state_e state_q, state_d;
  logic         fault_q, fault_d;
  logic         we;
  logic         clr;
  logic [ADR_W+CTRL_W-1:0] rdata;
  logic         rvalid;

  microcode_array #(
    .AW    (ADR_W),
    .DEPTH (DEPTH),
    .WW    (ADR_W + CTRL_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (we),
    .waddr_i  (load_addr),
    .wdata_i  (load_data),
    .clr_i    (clr),
    .raddr_i  (adr),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    we         = 1'b0;
    clr        = 1'b0;
    load_ready = 1'b0;
    run        = 1'b0;
    nextAdr    = '0;
    ctrl       = '0;
    unique case (state_q)
      LOAD: begin
        // Ready is held low while reset is asserted, even though the state already reads LOAD.
        load_ready = reset;
        we         = load_valid && load_ready;
        if (we && load_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (rvalid) begin
          {nextAdr, ctrl} = rdata;
        end else begin
          fault_d = 1'b1;
        end
        if (reload) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_microcode_store.sv
// tb/tb_microcode_store.sv - scoreboard bench for the microcode store
module tb_microcode_store;
  import micro_pkg::*;

  logic                    clk;
  logic                    reset;
  logic                    load_valid;
  logic                    load_ready;
  logic [ADR_W-1:0]        load_addr;
  logic [ADR_W+CTRL_W-1:0] load_data;
  logic                    load_last;
  logic                    reload;
  logic [ADR_W-1:0]        adr;
  logic [ADR_W-1:0]        nextAdr;
  logic [CTRL_W-1:0]       ctrl;
  logic                    run;
  logic                    fault;

  microcode_store dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_last  (load_last),
    .reload     (reload),
    .adr        (adr),
    .nextAdr    (nextAdr),
    .ctrl       (ctrl),
    .run        (run),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        run;
    logic        ready;
    micro_word_t word;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: drains every expectation queued during the first half of the cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++;
      if (run !== e.run || load_ready !== e.ready || nextAdr !== e.word.nextAdr ||
          ctrl !== e.word.ctrl || fault !== e.fault) begin
        n_fail++;
        $display("FAIL %s: got run=%0b ready=%0b nextAdr=%h ctrl=%h fault=%0b, expected run=%0b ready=%0b nextAdr=%h ctrl=%h fault=%0b",
                 e.name, run, load_ready, nextAdr, ctrl, fault,
                 e.run, e.ready, e.word.nextAdr, e.word.ctrl, e.fault);
      end
    end
  end

  task automatic expect_out(input string name, input logic r, input logic rdy,
                            input logic [ADR_W-1:0] na, input logic [CTRL_W-1:0] c,
                            input logic f);
    exp_t e;
    e.name         = name;
    e.run          = r;
    e.ready        = rdy;
    e.word.nextAdr = na;
    e.word.ctrl    = c;
    e.fault        = f;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic v, input logic [ADR_W-1:0] a,
                            input logic [ADR_W-1:0] na, input logic [CTRL_W-1:0] c,
                            input logic last);
    micro_word_t w;
    w.nextAdr  = na;
    w.ctrl     = c;
    load_valid = v;
    load_addr  = a;
    load_data  = w;
    load_last  = last;
  endtask

  initial begin
    reset = 1'b0;
    reload = 1'b0;
    adr = '0;
    drive_load(1'b0, 4'h0, 4'h0, 13'h0, 1'b0);

    step();
    expect_out("in_reset", 1'b0, 1'b0, 4'h0, 13'h0, 1'b0);
    step();
    reset = 1'b1;
    adr   = 4'h5;
    expect_out("reset_idle", 1'b0, 1'b1, 4'h0, 13'h0, 1'b0);

    drive_load(1'b1, 4'h0, 4'h1, 13'h0A5, 1'b0);
    expect_out("load_w0", 1'b0, 1'b1, 4'h0, 13'h0, 1'b0);
    step();
    drive_load(1'b1, 4'h1, DISPATCH_OP, 13'h100, 1'b1);
    expect_out("load_w1_last", 1'b0, 1'b1, 4'h0, 13'h0, 1'b0);
    step();
    drive_load(1'b0, 4'h0, 4'h0, 13'h0, 1'b0);
    adr = 4'h0;
    expect_out("read_adr0", 1'b1, 1'b0, 4'h1, 13'h0A5, 1'b0);
    step();
    adr = 4'h1;
    expect_out("read_dispatch", 1'b1, 1'b0, DISPATCH_OP, 13'h100, 1'b0);
    step();
    // Writes are refused in RUN.
    drive_load(1'b1, 4'h1, DISPATCH_FUNCT, 13'h0, 1'b1);
    adr = 4'h7;
    expect_out("unwritten_same_cycle", 1'b1, 1'b0, 4'h0, 13'h0, 1'b0);
    step();
    drive_load(1'b0, 4'h0, 4'h0, 13'h0, 1'b0);
    adr = 4'h1;
    expect_out("no_write_in_run", 1'b1, 1'b0, DISPATCH_OP, 13'h100, 1'b1);
    step();
    adr = 4'h0;
    expect_out("fault_sticky", 1'b1, 1'b0, 4'h1, 13'h0A5, 1'b1);

    reload = 1'b1;
    expect_out("reload_cycle_unaffected", 1'b1, 1'b0, 4'h1, 13'h0A5, 1'b1);
    step();
    reload = 1'b0;
    expect_out("reload_idle", 1'b0, 1'b1, 4'h0, 13'h0, 1'b1);
    load_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall_last_no_valid", 1'b0, 1'b1, 4'h0, 13'h0, 1'b1);
    end
    drive_load(1'b1, 4'h0, 4'h2, 13'h1FFF, 1'b1);
    reload = 1'b1;
    step();
    drive_load(1'b0, 4'h0, 4'h0, 13'h0, 1'b0);
    reload = 1'b0;
    expect_out("reload_word", 1'b1, 1'b0, 4'h2, 13'h1FFF, 1'b1);
    step();
    adr = 4'h1;
    expect_out("reload_cleared_valid", 1'b1, 1'b0, 4'h0, 13'h0, 1'b1);
    step();

    reset = 1'b0;
    #1;
    reset = 1'b1;
    adr = 4'h3;
    drive_load(1'b1, 4'h3, 4'h3, 13'h123, 1'b0);
    expect_out("reload_by_reset", 1'b0, 1'b1, 4'h0, 13'h0, 1'b0);
    step();
    drive_load(1'b0, 4'h0, 4'h0, 13'h0, 1'b0);
    #2;
    reset = 1'b0;
    expect_out("async_reset_mid_load", 1'b0, 1'b0, 4'h0, 13'h0, 1'b0);
    step();
    reset = 1'b1;
    drive_load(1'b1, 4'h0, 4'h4, 13'h055, 1'b1);
    step();
    drive_load(1'b0, 4'h0, 4'h0, 13'h0, 1'b0);
    expect_out("reset_invalidated_adr3", 1'b1, 1'b0, 4'h0, 13'h0, 1'b0);
    step();
    adr = 4'h0;
    expect_out("fault_after_reset_load", 1'b1, 1'b0, 4'h4, 13'h055, 1'b1);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microcode_store.md
Name: microcode_store

Overview:
- Writable control store for the micro-programmed controller.
- Serves the read side of the microprogram-address interface: takes the registered micro-address `adr` from the microprogram sequencer and returns that word's `nextAdr` field and control field in the same cycle.
- Loaded at boot through a valid/ready write port.
- Holds the sequencer at address 0 with an idle word until loading completes, and flags reads of unwritten entries.

Parameters:
- ADR_W, 4, micro-address width; must match sequencer `adr`/`nextAdr`.
- DEPTH, 16, number of microwords; equals 2**ADR_W.
- CTRL_W, 13, width of the control field of a microword.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  write request valid.
- load_ready  output  1  store accepts a write this cycle.
- load_addr  input  ADR_W  write address.
- load_data  input  ADR_W+CTRL_W  microword; layout {nextAdr, ctrl}, nextAdr in MSBs.
- load_last  input  1  marks the final word of the load burst.
- reload  input  1  request return to LOAD from RUN.
- adr  input  ADR_W  micro-address from sequencer.
- nextAdr  output  ADR_W  next-address field of word at `adr`; 1111/1110 are dispatch codes, passed through unchanged.
- ctrl  output  CTRL_W  control field of word at `adr`.
- run  output  1  store in RUN state.
- fault  output  1  sticky: an unwritten entry was read in RUN.

Behaviour:
- State encoding: 2-state FSM, LOAD and RUN.
- On reset low (async):
  - state=LOAD; all per-entry valid bits=0; fault=0.
  - Outputs during reset: run=0, load_ready=0, nextAdr=0, ctrl=0.
  - Array contents are not reset.
- LOAD state:
  - load_ready=1.
  - Handshake: a write occurs when load_valid && load_ready at the clock edge. mem[load_addr] <= load_data and valid[load_addr] <= 1.
  - Rewriting the same address overwrites it; last write wins.
  - load_valid with load_ready=0 performs no write. The master must hold its request; this block does not buffer.
  - Accepted write with load_last=1: state <= RUN. That word is written, and run=1 from the next cycle.
  - load_last without load_valid is ignored.
  - nextAdr=0 and ctrl=0 (idle word) regardless of `adr`, so the sequencer stays parked at 0.
- RUN state:
  - load_ready=0; run=1.
  - Combinational read, zero latency: nextAdr/ctrl = mem[adr] when valid[adr]=1.
  - If valid[adr]=0: outputs are the idle word (nextAdr=0, ctrl=0), and fault <= 1 at the next edge. fault stays 1 until reset.
  - reload=1: state <= LOAD at the edge and all valid bits are cleared. The current cycle's outputs are unaffected. fault is not cleared by reload.
- Simultaneous events:
  - reload in LOAD is ignored.
  - An accepted load_last in the same cycle as reload: load_last wins (→ RUN).
- Reset mid-load: partially written words are invalidated via the valid bits; loading restarts.
- Zero-cycle read path adr→nextAdr is required. The sequencer registers adr, so no combinational loop is created.

Decomposition:
- Shared package `micro_pkg`:
  - ADR_W, CTRL_W.
  - Dispatch codes DISPATCH_OP=4'b1111 and DISPATCH_FUNCT=4'b1110.
  - Microword struct {nextAdr, ctrl}.
  - FSM state enum {LOAD, RUN}.
- Sub-module `microcode_array`: DEPTH×(ADR_W+CTRL_W) storage with synchronous write, asynchronous read, and per-entry valid bits with a synchronous clear-all. FSM and handshake live in the top.

Test Plan:
- Reset then idle: hold reset=0 2 cycles, release, drive adr=4'h5 → run=0, load_ready=1, nextAdr=0, ctrl=0, fault=0.
- Burst load and read:
  - Write addr0={4'h1,13'h0A5}, addr1={4'hF,13'h100}; last on addr1.
  - Next cycle run=1.
  - adr=0 → nextAdr=1, ctrl=0x0A5.
  - adr=1 → nextAdr=4'hF, ctrl=0x100 (dispatch code passed through).
- Handshake stall: load_valid=0 with load_last=1 for 3 cycles → remains LOAD. Then load_valid=1 with load_last=1 → RUN the next cycle.
- Unwritten read: after the load above, adr=4'h7 → nextAdr=0, ctrl=0 same cycle; fault=1 next cycle and stays 1 after adr returns to 0.
- Reload:
  - In RUN pulse reload → state LOAD, run=0.
  - adr=0 yields the idle word.
  - Reload addr0={4'h2,13'h1FFF} with last → adr=0 gives nextAdr=2, ctrl=0x1FFF; fault still 1.
- Async reset mid-load: write addr3, assert reset=0 between edges → outputs zero immediately. Then load only addr0 with last, read adr=3 → fault=1.
